tiny_aes_keyexpansion: RTL and testbench



---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_sbox.sv | 12 +
 rtl/key_expand_stage.sv | 48 ++++
 rtl/tiny_aes_keyexpansion.sv | 71 +++++++
 tb/tb_tiny_aes_keyexpansion.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared constants for the AES-256 key schedule: S-box table, Rcon bytes, widths.
package aes_pkg;

  localparam int unsigned RK_W   = 128;
  localparam int unsigned KEY_W  = 256;
  localparam int unsigned ROUNDS = 14;

  // S-box, entry 0x00 in the top byte; look up with SBOX[~b] (index 255-b).
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Rcon[1..7]; index 0 is unused.
  localparam logic [7:0][7:0] RCON = {
    8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte combinational AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s_c
);

  // Table index is reversed because entry 0x00 is stored in the top byte.
  assign s_c = SBOX[~a];

endmodule

// File: rtl/key_expand_stage.sv
// One key-schedule pipeline stage: {K(n-2), K(n-1)} in, registered {K(n-1), K(n)} out.
module key_expand_stage
  import aes_pkg::*;
#(
  parameter bit         EVEN      = 1'b1,
  parameter logic [7:0] RCON_BYTE = 8'h00
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_W-1:0]     prev,
  output logic [KEY_W-1:0]     next
);

  logic [31:0] t;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] w0, w1, w2, w3;

  // Even stages rotate before substitution; odd stages substitute only.
  assign t      = prev[31:0];
  assign sub_in = EVEN ? {t[23:0], t[31:24]} : t;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a   (sub_in[8*b +: 8]),
      .s_c (sub_out[8*b +: 8])
    );
  end

  assign temp = EVEN ? (sub_out ^ {RCON_BYTE, 24'h000000}) : sub_out;

  // Four-word XOR chain against the round key two stages back.
  assign w0 = prev[255:224] ^ temp;
  assign w1 = prev[223:192] ^ w0;
  assign w2 = prev[191:160] ^ w1;
  assign w3 = prev[159:128] ^ w2;

  // Stage register; reset clears in-flight state.
  always_ff @(posedge clock) begin
    if (reset) begin
      next <= '0;
    end else begin
      next <= {prev[127:0], w0, w1, w2, w3};
    end
  end

endmodule

// File: rtl/tiny_aes_keyexpansion.sv
// Fully pipelined AES-256 key schedule; round key n appears n cycles after its key.
module tiny_aes_keyexpansion
  import aes_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [KEY_W-1:0] key,
  output logic [RK_W-1:0]  k1,
  output logic [RK_W-1:0]  k2,
  output logic [RK_W-1:0]  k3,
  output logic [RK_W-1:0]  k4,
  output logic [RK_W-1:0]  k5,
  output logic [RK_W-1:0]  k6,
  output logic [RK_W-1:0]  k7,
  output logic [RK_W-1:0]  k8,
  output logic [RK_W-1:0]  k9,
  output logic [RK_W-1:0]  k10,
  output logic [RK_W-1:0]  k11,
  output logic [RK_W-1:0]  k12,
  output logic [RK_W-1:0]  k13,
  output logic [RK_W-1:0]  k14
);

  logic [KEY_W-1:0] r1;
  logic [KEY_W-1:0] pipe [2:ROUNDS];

  // Stage 1 just captures the key: {K0, K1}.
  always_ff @(posedge clock) begin
    if (reset) begin
      r1 <= '0;
    end else begin
      r1 <= key;
    end
  end

  for (genvar n = 2; n <= ROUNDS; n++) begin : g_stage
    logic [KEY_W-1:0] prev_state;

    if (n == 2) begin : g_from_r1
      assign prev_state = r1;
    end else begin : g_from_pipe
      assign prev_state = pipe[n-1];
    end

    key_expand_stage #(
      .EVEN      ((n % 2) == 0),
      .RCON_BYTE (RCON[3'(n / 2)])
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .prev  (prev_state),
      .next  (pipe[n])
    );
  end

  assign k1  = r1[127:0];
  assign k2  = pipe[2][127:0];
  assign k3  = pipe[3][127:0];
  assign k4  = pipe[4][127:0];
  assign k5  = pipe[5][127:0];
  assign k6  = pipe[6][127:0];
  assign k7  = pipe[7][127:0];
  assign k8  = pipe[8][127:0];
  assign k9  = pipe[9][127:0];
  assign k10 = pipe[10][127:0];
  assign k11 = pipe[11][127:0];
  assign k12 = pipe[12][127:0];
  assign k13 = pipe[13][127:0];
  assign k14 = pipe[14][127:0];

endmodule

// File: tb/tb_tiny_aes_keyexpansion.sv
// Self-checking bench for the pipelined AES-256 key schedule.
module tb_tiny_aes_keyexpansion;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_K1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_K2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] FIPS_K3  = 128'h1651a8cd0244beda1a5da4c10640bade;
  localparam logic [127:0] FIPS_K4  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
  localparam logic [127:0] FIPS_K14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] ZERO_K2  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K3  = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

  logic         clock = 1'b0;
  logic         reset;
  logic [255:0] key;
  logic [127:0] kout [1:14];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   tb_sbox [0:255];
  logic [255:0] hist_key [0:4095];
  bit           hist_rst [0:4095];
  int           edge_cnt = 0;
  int           last_rst = 0;

  typedef struct {
    string        name;
    logic [255:0] key;
    int           n;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  always #5 clock = ~clock;

  tiny_aes_keyexpansion dut (
    .clock (clock),
    .reset (reset),
    .key   (key),
    .k1    (kout[1]),
    .k2    (kout[2]),
    .k3    (kout[3]),
    .k4    (kout[4]),
    .k5    (kout[5]),
    .k6    (kout[6]),
    .k7    (kout[7]),
    .k8    (kout[8]),
    .k9    (kout[9]),
    .k10   (kout[10]),
    .k11   (kout[11]),
    .k12   (kout[12]),
    .k13   (kout[13]),
    .k14   (kout[14])
  );

  // GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      if (a[7]) a = {a[6:0], 1'b0} ^ 8'h1b;
      else      a = {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box built from first principles: field inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (v != 0 && gmul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      tb_sbox[v] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
  endfunction

  // Textbook word-indexed AES-256 expansion; returns round key n.
  function automatic logic [127:0] ref_rk(input logic [255:0] k, input int n);
    logic [31:0] w [0:59];
    logic [31:0] temp;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc   = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  task automatic cmp(input string name, input int n, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k%0d: got %h expected %h (edge %0d)", name, n, act, exp, edge_cnt);
    end
  endtask

  // Advance one clock, log what the DUT sampled, settle past the edge.
  task automatic tick();
    @(posedge clock);
    edge_cnt++;
    hist_key[edge_cnt] = key;
    hist_rst[edge_cnt] = reset;
    if (reset) last_rst = edge_cnt;
    #1;
  endtask

  // Compare every output against the expansion of the key it should reflect.
  task automatic check_cycle(input string name);
    int src;
    for (int n = 1; n <= 14; n++) begin
      src = edge_cnt - n + 1;
      if (hist_rst[edge_cnt]) begin
        cmp({name, "_rst"}, n, kout[n], 128'h0);
      end else if (src >= 1 && src > last_rst) begin
        cmp(name, n, kout[n], ref_rk(hist_key[src], n));
      end
    end
  endtask

  task automatic tick_chk(input string name);
    tick();
    check_cycle(name);
  endtask

  initial begin
    vecs[0] = '{"fips_k1",  FIPS_KEY, 1,  FIPS_K1};
    vecs[1] = '{"fips_k2",  FIPS_KEY, 2,  FIPS_K2};
    vecs[2] = '{"fips_k3",  FIPS_KEY, 3,  FIPS_K3};
    vecs[3] = '{"fips_k4",  FIPS_KEY, 4,  FIPS_K4};
    vecs[4] = '{"fips_k14", FIPS_KEY, 14, FIPS_K14};
    vecs[5] = '{"zero_k1",  256'h0,   1,  128'h0};
    vecs[6] = '{"zero_k2",  256'h0,   2,  ZERO_K2};
    vecs[7] = '{"zero_k3",  256'h0,   3,  ZERO_K3};

    build_sbox();
    reset = 1'b1;
    key   = FIPS_KEY;
    tick();
    tick();
    for (int n = 1; n <= 14; n++) cmp("reset_state", n, kout[n], 128'h0);
    reset = 1'b0;

    // Held-key directed vectors.
    foreach (vecs[i]) begin
      key = vecs[i].key;
      repeat (14) tick_chk("hold");
      cmp(vecs[i].name, vecs[i].n, kout[vecs[i].n], vecs[i].exp);
    end

    // Latency: zero key is held, FIPS key applied from now on.
    key = FIPS_KEY;
    tick_chk("lat");
    cmp("lat_k1_t1", 1, kout[1], FIPS_K1);
    cmp("lat_k2_t1_old", 2, kout[2], ZERO_K2);
    tick_chk("lat");
    cmp("lat_k2_t2", 2, kout[2], FIPS_K2);
    repeat (11) tick_chk("lat");
    cmp("lat_k14_t13", 14, kout[14], ref_rk(256'h0, 14));
    tick_chk("lat");
    cmp("lat_k14_t14", 14, kout[14], FIPS_K14);

    // Back-to-back alternating keys.
    for (int i = 0; i < 40; i++) begin
      key = (i % 2 == 0) ? 256'h0 : FIPS_KEY;
      tick_chk("alt");
    end

    // Mid-stream reset pulse, then recovery with the FIPS key.
    reset = 1'b1;
    key   = 256'h0;
    tick_chk("midrst");
    for (int n = 1; n <= 14; n++) cmp("midrst_zero", n, kout[n], 128'h0);
    reset = 1'b0;
    key   = FIPS_KEY;
    tick_chk("recover");
    cmp("recover_k1", 1, kout[1], FIPS_K1);
    repeat (13) tick_chk("recover");
    cmp("recover_k14", 14, kout[14], FIPS_K14);

    // Random key stream, every output every cycle.
    for (int i = 0; i < 1100; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      tick_chk("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
